// File: rtl/morse_timing_ctrl.sv
// morse_timing_ctrl: turns key press/idle durations into Morse character, word-gap and error records
module morse_timing_ctrl #(
  parameter int DASH_TICK_COUNT           = 30_000_000,
  parameter int ILLEGAL_SYMBOL_TICK_COUNT = 100_000_000,
  parameter int INTER_IDLE_TICK_COUNT     = 175_000_000,
  parameter int WORD_IDLE_TICK_COUNT      = 250_000_000,
  parameter int CNT_W                     = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       sym_valid_o,
  input  logic       sym_ready_i,
  output logic [2:0] sym_len_o,
  output logic [4:0] sym_bits_o,
  output logic       sym_space_o,
  output logic       sym_err_o,
  output logic       ovf_o
);
  typedef enum logic [2:0] {IDLE, PRESS, GAP, WGAP, ERRW} state_t;
  localparam logic [CNT_W:0] L_DASH  = (CNT_W+1)'(DASH_TICK_COUNT);
  localparam logic [CNT_W:0] L_ILL   = (CNT_W+1)'(ILLEGAL_SYMBOL_TICK_COUNT);
  localparam logic [CNT_W:0] L_INTER = (CNT_W+1)'(INTER_IDLE_TICK_COUNT);
  localparam logic [CNT_W:0] L_WORD  = (CNT_W+1)'(WORD_IDLE_TICK_COUNT);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [CNT_W:0]   w_cnt_p1;
  logic [2:0]       r_len, w_len_nx, w_rec_len;
  logic [4:0]       r_bits, w_bits_nx, w_rec_bits;
  logic             w_emit, w_rec_space, w_rec_err, w_dash;
  logic             w_hit_ill, w_hit_inter, w_hit_word;
  logic             r_valid, r_space, r_err, r_ovf;
  logic [2:0]       r_sym_len;
  logic [4:0]       r_sym_bits;
  // one extra bit on the increment lets the counter saturate instead of wrapping
  assign w_cnt_p1    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_inc   = w_cnt_p1[CNT_W] ? r_cnt : w_cnt_p1[CNT_W-1:0];
  assign w_hit_ill   = w_cnt_p1 == L_ILL;
  assign w_hit_inter = w_cnt_p1 == L_INTER;
  assign w_hit_word  = w_cnt_p1 == L_WORD;
  assign w_dash      = {1'b0, r_cnt} >= L_DASH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_bits  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_len   <= w_len_nx;
      r_bits  <= w_bits_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = btn_i ? PRESS : IDLE;
      PRESS:   w_state_nx = btn_i ? (w_hit_ill ? ERRW : PRESS) : (r_len == 3'd5 ? WGAP : GAP);
      GAP:     w_state_nx = btn_i ? PRESS : (w_hit_inter ? WGAP : GAP);
      WGAP:    w_state_nx = btn_i ? PRESS : (w_hit_word ? IDLE : WGAP);
      ERRW:    w_state_nx = btn_i ? ERRW : WGAP;
      default: w_state_nx = IDLE;
    endcase
  end
  always_comb begin
    w_cnt_nx    = r_cnt;
    w_len_nx    = r_len;
    w_bits_nx   = r_bits;
    w_emit      = 1'b0;
    w_rec_len   = '0;
    w_rec_bits  = '0;
    w_rec_space = 1'b0;
    w_rec_err   = 1'b0;
    case (r_state)
      IDLE: if (btn_i) w_cnt_nx = L_ONE;
      PRESS: begin
        if (btn_i) begin
          w_cnt_nx = w_cnt_inc;
          if (w_hit_ill) begin
            w_len_nx  = '0;
            w_bits_nx = '0;
          end
        end else begin
          w_cnt_nx = L_ONE;
          if (r_len == 3'd5) begin
            w_emit    = 1'b1;
            w_rec_err = 1'b1;
            w_len_nx  = '0;
            w_bits_nx = '0;
          end else begin
            w_bits_nx = r_bits | (5'(w_dash) << r_len);
            w_len_nx  = r_len + 3'd1;
          end
        end
      end
      GAP: begin
        w_cnt_nx = btn_i ? L_ONE : w_cnt_inc;
        if (!btn_i && w_hit_inter) begin
          w_emit     = 1'b1;
          w_rec_len  = r_len;
          w_rec_bits = r_bits;
          w_len_nx   = '0;
          w_bits_nx  = '0;
        end
      end
      WGAP: begin
        w_cnt_nx    = btn_i ? L_ONE : (w_hit_word ? r_cnt : w_cnt_inc);
        w_emit      = !btn_i && w_hit_word;
        w_rec_space = w_emit;
      end
      ERRW: begin
        w_cnt_nx  = btn_i ? r_cnt : L_ONE;
        w_emit    = !btn_i;
        w_rec_err = !btn_i;
      end
      default: ;
    endcase
  end
  // single holding register; a record arriving while one is stuck is lost and flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_sym_len  <= '0;
      r_sym_bits <= '0;
      r_space    <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || sym_ready_i)) begin
        r_valid    <= 1'b1;
        r_sym_len  <= w_rec_len;
        r_sym_bits <= w_rec_bits;
        r_space    <= w_rec_space;
        r_err      <= w_rec_err;
      end else if (r_valid && sym_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_emit && r_valid && !sym_ready_i) r_ovf <= 1'b1;
    end
  end
  assign sym_valid_o = r_valid;
  assign sym_len_o   = r_sym_len;
  assign sym_bits_o  = r_sym_bits;
  assign sym_space_o = r_space;
  assign sym_err_o   = r_err;
  assign ovf_o       = r_ovf;
endmodule
